// File: rtl/dir_array_pkg.sv
// Shared definitions for the directory array: sweep state encoding and
// the address-width helper used to size row ports.
package dir_array_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/dir_array_init.sv
// INIT/READY sequencer: walks a row counter across the array after reset
// or on request, then opens the array for normal reads and writes.
module dir_array_init
  import dir_array_pkg::*;
#(
  parameter int ROWS  = 128,
  parameter int ADR_W = 7
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             init_req_i,
  output logic             ready_o,
  output logic             sweep_o,
  output logic [ADR_W-1:0] sweep_adr_o
);

  localparam logic [ADR_W-1:0] LAST_ROW = ADR_W'(ROWS - 1);

  state_e           state_q;
  logic [ADR_W-1:0] cnt_q;
  logic             ready_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (cnt_q == LAST_ROW) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_READY: begin
          if (init_req_i) begin
            state_q <= ST_INIT;
            ready_q <= 1'b0;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_INIT;
          ready_q <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign ready_o     = ready_q;
  assign sweep_o     = !ready_q;
  assign sweep_adr_o = cnt_q;

endmodule

// File: rtl/dir_array.sv
// One-read/one-write directory array with lane write enables, clear sweep,
// same-cycle write bypass, optional per-lane parity and a registered read.
module dir_array
  import dir_array_pkg::*;
#(
  parameter int              ROWS     = 128,
  parameter int              BITS     = 32,
  parameter int              LANE     = 8,
  parameter int              BYPASS   = 1,
  parameter int              PARITY   = 0,
  parameter logic [BITS-1:0] INIT_VAL = '0,
  localparam int             ADR_W    = clog2(ROWS),
  localparam int             LANES    = BITS / LANE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init_req,
  output logic             ready,
  input  logic             rd_val,
  input  logic [ADR_W-1:0] rd_adr,
  output logic             rd_dat_val,
  output logic [BITS-1:0]  rd_dat,
  output logic [LANES-1:0] rd_perr,
  input  logic [LANES-1:0] wr_en,
  input  logic [ADR_W-1:0] wr_adr,
  input  logic [BITS-1:0]  wr_dat,
  input  logic [LANES-1:0] wr_perr_inj
);

  localparam logic [ADR_W:0] ROWS_L = (ADR_W + 1)'(ROWS);

  logic             sweep;
  logic [ADR_W-1:0] sweep_adr;

  dir_array_init #(
    .ROWS  (ROWS),
    .ADR_W (ADR_W)
  ) u_init (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .init_req_i  (init_req & ready),
    .ready_o     (ready),
    .sweep_o     (sweep),
    .sweep_adr_o (sweep_adr)
  );

  logic             rd_in_rng, wr_in_rng, rd_acc;
  logic [LANES-1:0] w_en;
  logic [ADR_W-1:0] w_adr;
  logic [BITS-1:0]  w_dat;
  logic [LANES-1:0] w_inj, w_par;

  assign rd_in_rng = {1'b0, rd_adr} < ROWS_L;
  assign wr_in_rng = {1'b0, wr_adr} < ROWS_L;
  assign rd_acc    = ready & rd_val;

  // Sweep owns the write port; user writes only get through once ready.
  always_comb begin
    w_en  = '0;
    w_adr = wr_adr;
    w_dat = wr_dat;
    w_inj = '0;
    if (sweep) begin
      w_en  = '1;
      w_adr = sweep_adr;
      w_dat = INIT_VAL;
    end else if (ready && wr_in_rng) begin
      w_en  = wr_en;
      w_inj = wr_perr_inj;
    end
    for (int unsigned i = 0; i < LANES; i++)
      w_par[i] = (^w_dat[i*LANE +: LANE]) ^ w_inj[i];
  end

  logic [BITS-1:0] mem [ROWS];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LANES; i++)
      if (w_en[i]) mem[w_adr][i*LANE +: LANE] <= w_dat[i*LANE +: LANE];
  end

  logic [LANES-1:0] s_par;

  if (PARITY != 0) begin : g_par
    logic [LANES-1:0] pmem [ROWS];
    always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < LANES; i++)
        if (w_en[i]) pmem[w_adr][i] <= w_par[i];
    end
    assign s_par = pmem[rd_adr];
  end else begin : g_nopar
    assign s_par = '0;
  end

  logic [BITS-1:0]  r_dat;
  logic [LANES-1:0] r_spar, r_perr;
  logic             byp_hit;

  assign byp_hit = (BYPASS != 0) && !sweep && (rd_adr == wr_adr);

  always_comb begin
    r_dat  = mem[rd_adr];
    r_spar = s_par;
    r_perr = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (byp_hit && w_en[i]) begin
        r_dat[i*LANE +: LANE] = wr_dat[i*LANE +: LANE];
        r_spar[i]             = w_par[i];
      end
      if (PARITY != 0) r_perr[i] = (^r_dat[i*LANE +: LANE]) ^ r_spar[i];
    end
    if (!rd_in_rng) begin
      r_dat  = INIT_VAL;
      r_perr = '0;
    end
  end

  logic             rd_dat_val_q;
  logic [BITS-1:0]  rd_dat_q;
  logic [LANES-1:0] rd_perr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_dat_val_q <= 1'b0;
      rd_dat_q     <= '0;
      rd_perr_q    <= '0;
    end else begin
      rd_dat_val_q <= rd_acc;
      if (rd_acc) begin
        rd_dat_q  <= r_dat;
        rd_perr_q <= r_perr;
      end
    end
  end

  assign rd_dat_val = rd_dat_val_q;
  assign rd_dat     = rd_dat_q;
  assign rd_perr    = rd_perr_q;

endmodule

// File: tb/tb_dir_array.sv
// Scoreboard bench for dir_array (128x32, 8-bit lanes, bypass and parity on).
module tb_dir_array;

  localparam int          ROWS  = 128;
  localparam int          BITS  = 32;
  localparam int          LANES = 4;
  localparam logic [31:0] IV    = 32'h0F0F_3C3C;

  logic        clk = 1'b0;
  logic        rst_n, init_req, ready;
  logic        rd_val, rd_dat_val;
  logic [6:0]  rd_adr, wr_adr;
  logic [31:0] rd_dat, wr_dat;
  logic [3:0]  rd_perr, wr_en, wr_perr_inj;

  int errors = 0;
  int checks = 0;
  logic [35:0] exp_q [$];

  always #5 clk = ~clk;

  dir_array #(
    .ROWS     (ROWS),
    .BITS     (BITS),
    .LANE     (8),
    .BYPASS   (1),
    .PARITY   (1),
    .INIT_VAL (IV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .init_req    (init_req),
    .ready       (ready),
    .rd_val      (rd_val),
    .rd_adr      (rd_adr),
    .rd_dat_val  (rd_dat_val),
    .rd_dat      (rd_dat),
    .rd_perr     (rd_perr),
    .wr_en       (wr_en),
    .wr_adr      (wr_adr),
    .wr_dat      (wr_dat),
    .wr_perr_inj (wr_perr_inj)
  );

  // Monitor: every valid read pops one expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rd_dat_val === 1'b1) begin
      logic [35:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rd: dat=%h perr=%b with no read pending", rd_dat, rd_perr);
      end else begin
        e = exp_q.pop_front();
        if ({rd_perr, rd_dat} !== e) begin
          errors++;
          $display("FAIL rd_data: got dat=%h perr=%b, want dat=%h perr=%b",
                   rd_dat, rd_perr, e[31:0], e[35:32]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus; exp_ok queues an expectation for the read.
  task automatic op(input logic rv, input logic [6:0] ra, input logic exp_ok,
                    input logic [31:0] ed, input logic [3:0] ep,
                    input logic [3:0] we, input logic [6:0] wa,
                    input logic [31:0] wd, input logic [3:0] inj, input logic ir);
    rd_val = rv; rd_adr = ra; wr_en = we; wr_adr = wa; wr_dat = wd;
    wr_perr_inj = inj; init_req = ir;
    if (rv && exp_ok) exp_q.push_back({ep, ed});
    tick();
    rd_val = 1'b0; wr_en = '0; wr_perr_inj = '0; init_req = 1'b0;
  endtask

  task automatic rd(input logic [6:0] a, input logic [31:0] ed, input logic [3:0] ep);
    op(1'b1, a, 1'b1, ed, ep, 4'h0, 7'd0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d, input logic [3:0] we,
                    input logic [3:0] inj);
    op(1'b0, 7'd0, 1'b0, 32'h0, 4'h0, we, a, d, inj, 1'b0);
  endtask

  // ready must stay low for edges 1..ROWS-1 and rise on edge ROWS.
  task automatic sweep_check(input string name);
    int bad;
    bad = 0;
    for (int c = 1; c <= ROWS; c++) begin
      tick();
      if (ready !== (c == ROWS)) bad++;
      if (c == ROWS / 2) op(1'b1, 7'd2, 1'b0, 32'h0, 4'h0, 4'hF, 7'd2, 32'h2222_2222, 4'h0, 1'b0);
      if (c == ROWS / 2) c++;
    end
    check(name, 64'(bad), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; init_req = 1'b0; rd_val = 1'b0; rd_adr = '0;
    wr_en = '0; wr_adr = '0; wr_dat = '0; wr_perr_inj = '0;
    repeat (3) tick();
    check("reset_ready",  64'(ready), 64'd0);
    check("reset_rdval",  64'(rd_dat_val), 64'd0);
    check("reset_rddat",  64'(rd_dat), 64'd0);
    check("reset_rdperr", 64'(rd_perr), 64'd0);
    rst_n = 1'b1;
    sweep_check("post_reset_sweep");

    rd(7'd0,   IV, 4'h0);
    rd(7'd64,  IV, 4'h0);
    rd(7'd127, IV, 4'h0);

    wr(7'd5, 32'h1111_1111, 4'hF, 4'h0);
    wr(7'd5, 32'hDEAD_BEEF, 4'b0101, 4'h0);
    rd(7'd5, 32'h11AD_11EF, 4'h0);

    wr(7'd9, 32'h1234_5678, 4'hF, 4'h0);
    op(1'b1, 7'd9, 1'b1, 32'hCAFE_F00D, 4'h0, 4'hF, 7'd9, 32'hCAFE_F00D, 4'h0, 1'b0);
    rd(7'd9, 32'hCAFE_F00D, 4'h0);
    op(1'b1, 7'd9, 1'b1, 32'hFFFE_F00D, 4'h0, 4'b1000, 7'd9, 32'hFFFF_FFFF, 4'h0, 1'b0);
    rd(7'd9, 32'hFFFE_F00D, 4'h0);
    op(1'b1, 7'd9, 1'b1, 32'hFFFE_F00D, 4'h0, 4'hF, 7'd10, 32'h0, 4'h0, 1'b0);

    wr(7'd3, 32'h0102_0304, 4'hF, 4'b0010);
    rd(7'd3, 32'h0102_0304, 4'b0010);
    wr(7'd3, 32'h0102_0304, 4'hF, 4'h0);
    rd(7'd3, 32'h0102_0304, 4'h0);
    op(1'b1, 7'd3, 1'b1, 32'hA0B0_C0D0, 4'b0100, 4'hF, 7'd3, 32'hA0B0_C0D0, 4'b0100, 1'b0);
    rd(7'd3, 32'hA0B0_C0D0, 4'b0100);

    wr(7'd2, 32'h5555_5555, 4'hF, 4'h0);
    op(1'b1, 7'd7, 1'b1, 32'h7777_7777, 4'h0, 4'hF, 7'd7, 32'h7777_7777, 4'h0, 1'b1);
    check("init_req_drop", 64'(ready), 64'd0);
    sweep_check("init_req_sweep");
    rd(7'd7, IV, 4'h0);
    rd(7'd2, IV, 4'h0);
    rd(7'd3, IV, 4'h0);

    op(1'b0, 7'd0, 1'b0, 32'h0, 4'h0, 4'h0, 7'd0, 32'h0, 4'h0, 1'b1);
    repeat (60) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midsweep_rst_rddat", 64'(rd_dat), 64'd0);
    sweep_check("midsweep_rst_sweep");
    rd(7'd100, IV, 4'h0);

    repeat (3) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
